// File: rtl/free_list_ckpt_if.sv
// Handshake bundle for the checkpointed free list: allocation, free return,
// checkpoint save/restore controls and status outputs.
interface free_list_ckpt_if #(
  parameter int TAG_W    = 8,
  parameter int DEPTH    = 128,
  parameter int NUM_CKPT = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int CID_W = $clog2(NUM_CKPT);

  logic                alloc_req;
  logic                alloc_valid;
  logic [TAG_W-1:0]    alloc_tag;
  logic                free_valid;
  logic [TAG_W-1:0]    free_tag;
  logic                ckpt_save;
  logic [CID_W-1:0]    ckpt_save_id;
  logic                ckpt_restore;
  logic [CID_W-1:0]    ckpt_restore_id;
  logic [CNT_W-1:0]    count;
  logic                full;
  logic [NUM_CKPT-1:0] ckpt_valid;
  logic                err;

  // Consumer / rename side.
  modport master (
    output alloc_req, free_valid, free_tag, ckpt_save, ckpt_save_id,
           ckpt_restore, ckpt_restore_id,
    input  alloc_valid, alloc_tag, count, full, ckpt_valid, err
  );

  // Free-list side.
  modport slave (
    input  alloc_req, free_valid, free_tag, ckpt_save, ckpt_save_id,
           ckpt_restore, ckpt_restore_id,
    output alloc_valid, alloc_tag, count, full, ckpt_valid, err
  );
endinterface

// File: rtl/free_list_ckpt.sv
// Physical-tag free list with head-pointer checkpoints.
// Circular tag array, head/tail pointers carrying a wrap bit, show-ahead
// allocation, and NUM_CKPT saved head pointers that can rewind allocation.
module free_list_ckpt #(
  parameter int TAG_W    = 8,
  parameter int DEPTH    = 128,
  parameter int TAG_BASE = 32,
  parameter int NUM_CKPT = 8
) (
  input  logic            clk,
  input  logic            reset,
  free_list_ckpt_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [TAG_W-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [PTR_W-1:0]    r_count;
  logic [PTR_W-1:0]    r_ckpt_head [NUM_CKPT];
  logic [NUM_CKPT-1:0] r_ckpt_valid;
  logic                r_err;

  logic                w_alloc_valid;
  logic                w_full;
  logic                w_restore_ok;
  logic                w_restore_bad;
  logic                w_alloc_ok;
  logic                w_alloc_bad;
  logic                w_free_ok;
  logic                w_free_bad;
  logic [PTR_W-1:0]    w_head_nxt;
  logic [PTR_W-1:0]    w_tail_nxt;
  logic [NUM_CKPT-1:0] w_ckpt_valid_nxt;

  // Status is derived from the registered count so it carries no input paths.
  assign w_alloc_valid   = (r_count != '0);
  assign w_full          = (r_count == PTR_W'(DEPTH));
  assign bus.alloc_valid = w_alloc_valid;
  assign bus.alloc_tag   = r_mem[r_head[IDX_W-1:0]];
  assign bus.count       = r_count;
  assign bus.full        = w_full;
  assign bus.ckpt_valid  = r_ckpt_valid;
  assign bus.err         = r_err;

  // Accept/reject decisions and next-state pointers and checkpoint mask.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave a value unassigned and infer a latch.
    w_ckpt_valid_nxt = r_ckpt_valid;

    w_restore_ok  = bus.ckpt_restore &  r_ckpt_valid[bus.ckpt_restore_id];
    w_restore_bad = bus.ckpt_restore & ~r_ckpt_valid[bus.ckpt_restore_id];
    // A valid restore owns the head this cycle; the colliding alloc is simply
    // not granted and is not an error.
    w_alloc_ok    = bus.alloc_req &  w_alloc_valid & ~w_restore_ok;
    w_alloc_bad   = bus.alloc_req & ~w_alloc_valid & ~w_restore_ok;
    w_free_ok     = bus.free_valid & ~w_full;
    w_free_bad    = bus.free_valid &  w_full;

    w_head_nxt = w_restore_ok ? r_ckpt_head[bus.ckpt_restore_id]
                              : r_head + PTR_W'(w_alloc_ok);
    w_tail_nxt = r_tail + PTR_W'(w_free_ok);

    // A free landing a full lap past a saved head overwrites a tag that slot
    // would hand out again, so that slot can no longer be restored.
    for (int i = 0; i < NUM_CKPT; i++) begin
      if (w_free_ok && ((r_tail - r_ckpt_head[i]) == PTR_W'(DEPTH))) begin
        w_ckpt_valid_nxt[i] = 1'b0;
      end
    end
    // A save captures the post-restore/post-alloc head, which is always
    // within one lap of the new tail, so it may re-validate the slot.
    if (bus.ckpt_save) begin
      w_ckpt_valid_nxt[bus.ckpt_save_id] = 1'b1;
    end
  end

  // Pointer, count, checkpoint and error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head       <= '0;
      r_tail       <= PTR_W'(DEPTH);
      r_count      <= PTR_W'(DEPTH);
      r_ckpt_valid <= '0;
      r_err        <= 1'b0;
      for (int i = 0; i < NUM_CKPT; i++) begin
        r_ckpt_head[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_head       <= w_head_nxt;
      r_tail       <= w_tail_nxt;
      r_count      <= w_tail_nxt - w_head_nxt;
      r_ckpt_valid <= w_ckpt_valid_nxt;
      r_err        <= w_alloc_bad | w_free_bad | w_restore_bad;
      if (bus.ckpt_save) begin
        r_ckpt_head[bus.ckpt_save_id] <= w_head_nxt;
      end
    end
  end

  // Tag array: preloaded with TAG_BASE.. on reset, written at tail on free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: this array is deliberately reset, unlike a plain RAM, because
      // its reset contents are the initial pool of free tags.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= TAG_W'(TAG_BASE + i);
      end
    end else if (w_free_ok) begin
      r_mem[r_tail[IDX_W-1:0]] <= bus.free_tag;
    end
  end
endmodule
